// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side types and constants.
package rv32i_pkg;
  localparam int          XLEN         = 32;
  localparam int          IMEM_ADDR_W  = 8;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // One prefetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, instr}; head comes straight from storage registers.
// A push into a full queue is accepted only alongside a pop.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [XLEN-1:0]            push_instr,
  output logic                       head_valid,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic                   do_push, do_pop;

  // Pops on empty are ignored; pushes on full need a same-cycle pop.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < CNT_W'(DEPTH)) | do_pop);

  assign head_valid = (count != '0);
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  // Storage, pointer and occupancy update; flush empties without touching data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational ROM address,
// prefetches into fetch_queue and handles redirects with flush.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              misaligned
);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_state_t     state;
  logic [31:0]      pc;
  logic [CNT_W-1:0] count;
  logic             pop, push;

  assign imem_addr = pc[ADDR_W+1:2];
  assign pop       = out_valid & out_ready;
  assign push      = (state == RUN) & fetch_en & ~redirect &
                     ((count < CNT_W'(DEPTH)) | pop);

  // PC, fetch FSM and misaligned-redirect flag; redirect beats sequential fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect & (redirect_pc[1:0] != 2'b00);
      state      <= fetch_en ? RUN : IDLE;
      if (redirect)  pc <= {redirect_pc[31:2], 2'b00};
      else if (push) pc <= pc + 32'd4;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .push_pc    (pc),
    .push_instr (imem_data),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (count)
  );
endmodule
